// File: rtl/button_event_arbiter.sv
// Purpose: turns debounced button levels into press and auto-repeat events, arbitrated round-robin onto one stream.
// Latency: a press is pending at the edge that samples the rise; o_Event_Valid rises one edge later if the output is free.
// Backpressure: o_Event_Valid/i_Event_Ready; pending holds one event per button, and a further event for a pending button pulses o_Drop.
//
// Ports:
//   i_Clk, i_Rst_L      clock, asynchronous active-low reset
//   i_Buttons           debounced levels, 1 = pressed
//   o_Event_Valid       event present on o_Event_Index / o_Event_Repeat
//   i_Event_Ready       consumer takes the event when high with valid
//   o_Event_Index       button number of the current event
//   o_Event_Repeat      0 = initial press, 1 = auto-repeat
//   o_Drop              one-cycle pulse when an event is lost
module button_event_arbiter #(
    parameter int NUM_BUTTONS  = 4,
    parameter int IDX_WIDTH    = 2,
    parameter int REPEAT_DELAY = 12500000,
    parameter int REPEAT_RATE  = 2500000,
    parameter int CNT_WIDTH    = 24
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_L,
    input  logic [NUM_BUTTONS-1:0] i_Buttons,
    output logic                   o_Event_Valid,
    input  logic                   i_Event_Ready,
    output logic [IDX_WIDTH-1:0]   o_Event_Index,
    output logic                   o_Event_Repeat,
    output logic                   o_Drop
);

    localparam logic [CNT_WIDTH-1:0] DELAY_TERM =
        CNT_WIDTH'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [CNT_WIDTH-1:0] RATE_TERM =
        CNT_WIDTH'((REPEAT_RATE > 0) ? REPEAT_RATE - 1 : 0);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_BUTTONS - 1);
    localparam bit REPEAT_EN = (REPEAT_DELAY != 0);

    typedef enum logic [1:0] {
        T_IDLE   = 2'd0,
        T_DELAY  = 2'd1,
        T_REPEAT = 2'd2
    } timer_state_t;

    // Edge detection and arming
    logic [NUM_BUTTONS-1:0] r_Prev;
    logic                   r_Armed;
    logic [NUM_BUTTONS-1:0] rise;
    logic                   any_rise;
    logic [IDX_WIDTH-1:0]   first_rise;

    // Pending event slots
    logic [NUM_BUTTONS-1:0] r_Pend;
    logic [NUM_BUTTONS-1:0] r_Rep;
    logic [IDX_WIDTH-1:0]   r_Ptr;
    logic [NUM_BUTTONS-1:0] pend_nxt;
    logic [NUM_BUTTONS-1:0] rep_nxt;
    logic                   drop_nxt;

    // Arbitration
    logic                   load;
    logic                   found;
    logic [IDX_WIDTH-1:0]   sel;
    logic [NUM_BUTTONS-1:0] clr_vec;
    logic [NUM_BUTTONS-1:0] set_vec;

    // Shared repeat timer
    timer_state_t           r_State;
    logic [IDX_WIDTH-1:0]   r_Owner;
    logic [CNT_WIDTH-1:0]   r_Count;
    logic                   tick_now;
    logic [NUM_BUTTONS-1:0] tick_vec;

    // A button already down when the bank is first sampled is not a press.
    always_comb begin
        rise     = r_Armed ? (i_Buttons & ~r_Prev) : '0;
        any_rise = |rise;
    end

    // Lowest-index rising button becomes the new timer owner.
    always_comb begin
        first_rise = '0;
        for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
            if (rise[i]) begin
                first_rise = IDX_WIDTH'(i);
            end
        end
    end

    // A fresh rise retargets the timer, and a released owner stops it, so
    // neither case may tick in the same cycle.
    always_comb begin
        tick_now = 1'b0;
        if (!any_rise && i_Buttons[r_Owner]) begin
            case (r_State)
                T_DELAY:  tick_now = (r_Count == DELAY_TERM);
                T_REPEAT: tick_now = (r_Count == RATE_TERM);
                default:  tick_now = 1'b0;
            endcase
        end
        tick_vec = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            tick_vec[i] = tick_now && (r_Owner == IDX_WIDTH'(i));
        end
    end

    // Round-robin pick: the first pass covers indices at or above the
    // pointer; the second pass only matters when the first found nothing,
    // and then picks the lowest index, which is the wrap-around winner.
    always_comb begin
        load  = !o_Event_Valid || i_Event_Ready;
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (!found && r_Pend[i] && (IDX_WIDTH'(i) >= r_Ptr)) begin
                found = 1'b1;
                sel   = IDX_WIDTH'(i);
            end
        end
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (!found && r_Pend[i]) begin
                found = 1'b1;
                sel   = IDX_WIDTH'(i);
            end
        end
        clr_vec = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            clr_vec[i] = load && found && (sel == IDX_WIDTH'(i));
        end
    end

    // Press beats repeat for the same button. A slot that is being handed
    // to the output this cycle can take a new event without loss.
    always_comb begin
        set_vec  = rise | tick_vec;
        pend_nxt = r_Pend;
        rep_nxt  = r_Rep;
        drop_nxt = 1'b0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (set_vec[i]) begin
                if (r_Pend[i] && !clr_vec[i]) begin
                    drop_nxt = 1'b1;
                end else begin
                    pend_nxt[i] = 1'b1;
                    rep_nxt[i]  = !rise[i];
                end
            end else if (clr_vec[i]) begin
                pend_nxt[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_Prev         <= '0;
            r_Armed        <= 1'b0;
            r_Pend         <= '0;
            r_Rep          <= '0;
            r_Ptr          <= '0;
            o_Event_Valid  <= 1'b0;
            o_Event_Index  <= '0;
            o_Event_Repeat <= 1'b0;
            o_Drop         <= 1'b0;
        end else begin
            r_Prev  <= i_Buttons;
            r_Armed <= 1'b1;
            r_Pend  <= pend_nxt;
            r_Rep   <= rep_nxt;
            o_Drop  <= drop_nxt;
            if (load) begin
                o_Event_Valid <= found;
                if (found) begin
                    o_Event_Index  <= sel;
                    o_Event_Repeat <= r_Rep[sel];
                    r_Ptr          <= (sel == LAST_IDX) ? '0 : sel + 1'b1;
                end
            end
        end
    end

    // Single shared repeat timer. The count restarts on every retarget or
    // tick, so equality against the terminal value is enough.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_State <= T_IDLE;
            r_Owner <= '0;
            r_Count <= '0;
        end else begin
            case (r_State)
                T_IDLE: begin
                    if (REPEAT_EN && any_rise) begin
                        r_Owner <= first_rise;
                        r_Count <= '0;
                        r_State <= T_DELAY;
                    end
                end
                T_DELAY, T_REPEAT: begin
                    if (any_rise) begin
                        r_Owner <= first_rise;
                        r_Count <= '0;
                        r_State <= T_DELAY;
                    end else if (!i_Buttons[r_Owner]) begin
                        r_Count <= '0;
                        r_State <= T_IDLE;
                    end else if (tick_now) begin
                        r_Count <= '0;
                        r_State <= T_REPEAT;
                    end else begin
                        r_Count <= r_Count + 1'b1;
                    end
                end
                default: begin
                    r_Count <= '0;
                    r_State <= T_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Purpose: randomized and directed stimulus for button_event_arbiter against an event-level reference model.
// Latency: the model is stepped once per clock edge and compared at the following falling edge.
// Backpressure: i_Event_Ready is randomized, including long stalls that force drops.
module tb_button_event_arbiter;

    localparam int NB = 4;
    localparam int IW = 2;
    localparam int D  = 10;
    localparam int R  = 4;

    logic          i_Clk;
    logic          i_Rst_L;
    logic [NB-1:0] i_Buttons;
    logic          o_Event_Valid;
    logic          i_Event_Ready;
    logic [IW-1:0] o_Event_Index;
    logic          o_Event_Repeat;
    logic          o_Drop;

    button_event_arbiter #(
        .NUM_BUTTONS  (NB),
        .IDX_WIDTH    (IW),
        .REPEAT_DELAY (D),
        .REPEAT_RATE  (R),
        .CNT_WIDTH    (8)
    ) dut (
        .i_Clk          (i_Clk),
        .i_Rst_L        (i_Rst_L),
        .i_Buttons      (i_Buttons),
        .o_Event_Valid  (o_Event_Valid),
        .i_Event_Ready  (i_Event_Ready),
        .o_Event_Index  (o_Event_Index),
        .o_Event_Repeat (o_Event_Repeat),
        .o_Drop         (o_Drop)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: edge counts since the last retarget decide repeats.
    bit m_armed;
    bit m_prev [NB];
    bit m_pend [NB];
    bit m_rep  [NB];
    int m_ptr;
    bit m_valid;
    int m_idx;
    bit m_rpt;
    bit m_drop;
    int m_owner;
    int m_t0;
    int m_cyc;

    task automatic model_reset();
        m_armed = 0;
        for (int i = 0; i < NB; i++) begin
            m_prev[i] = 0;
            m_pend[i] = 0;
            m_rep[i]  = 0;
        end
        m_ptr   = 0;
        m_valid = 0;
        m_idx   = 0;
        m_rpt   = 0;
        m_drop  = 0;
        m_owner = -1;
        m_t0    = 0;
        m_cyc   = 0;
    endtask

    task automatic model_step(input logic [NB-1:0] b, input logic rdy);
        bit rise [NB];
        bit tick [NB];
        bit any_rise;
        int el;
        int got;
        any_rise = 0;
        m_cyc++;
        for (int i = 0; i < NB; i++) begin
            rise[i]  = m_armed && b[i] && !m_prev[i];
            tick[i]  = 0;
            any_rise = any_rise | rise[i];
        end
        // Repeat schedule: D edges after the most recent press, then every R.
        if (any_rise && D > 0) begin
            for (int i = NB - 1; i >= 0; i--) if (rise[i]) m_owner = i;
            m_t0 = m_cyc;
        end else if (m_owner >= 0) begin
            if (!b[m_owner]) begin
                m_owner = -1;
            end else begin
                el = m_cyc - m_t0;
                if (el == D || (el > D && ((el - D) % R) == 0)) tick[m_owner] = 1;
            end
        end
        // The output slot takes one pending event, searching from the pointer.
        if (!m_valid || rdy) begin
            got = -1;
            for (int k = 0; k < NB; k++) begin
                if (got < 0 && m_pend[(m_ptr + k) % NB]) got = (m_ptr + k) % NB;
            end
            if (got >= 0) begin
                m_valid     = 1;
                m_idx       = got;
                m_rpt       = m_rep[got];
                m_pend[got] = 0;
                m_ptr       = (got + 1) % NB;
            end else begin
                m_valid = 0;
            end
        end
        // New events land after the hand-off, so a just-emptied slot accepts one.
        m_drop = 0;
        for (int i = 0; i < NB; i++) begin
            if (rise[i] || tick[i]) begin
                if (m_pend[i]) begin
                    m_drop = 1;
                end else begin
                    m_pend[i] = 1;
                    m_rep[i]  = !rise[i];
                end
            end
            m_prev[i] = b[i];
        end
        m_armed = 1;
    endtask

    task automatic compare_outputs();
        check("valid", o_Event_Valid, m_valid);
        if (m_valid) begin
            check("index", o_Event_Index, m_idx);
            check("repeat", o_Event_Repeat, m_rpt);
        end
        check("drop", o_Drop, m_drop);
    endtask

    task automatic run_cycle(input logic [NB-1:0] b, input logic rdy);
        @(negedge i_Clk);
        compare_outputs();
        i_Buttons     = b;
        i_Event_Ready = rdy;
        @(posedge i_Clk);
        model_step(b, rdy);
    endtask

    task automatic run_n(input logic [NB-1:0] b, input logic rdy, input int n);
        for (int c = 0; c < n; c++) run_cycle(b, rdy);
    endtask

    // Reset lands between clock edges; outputs must clear without a clock.
    task automatic do_async_reset(input logic [NB-1:0] b);
        @(negedge i_Clk);
        i_Buttons = b;
        #2 i_Rst_L = 1'b0;
        #1;
        check("rst_valid", o_Event_Valid, 0);
        check("rst_index", o_Event_Index, 0);
        check("rst_repeat", o_Event_Repeat, 0);
        check("rst_drop", o_Drop, 0);
        model_reset();
        @(posedge i_Clk);
        #2 i_Rst_L = 1'b1;
    endtask

    initial begin
        logic [NB-1:0] btn;
        logic          rdy;
        int            k;

        i_Rst_L       = 1'b0;
        i_Buttons     = '0;
        i_Event_Ready = 1'b0;
        model_reset();
        #1;
        check("init_valid", o_Event_Valid, 0);
        check("init_index", o_Event_Index, 0);
        check("init_repeat", o_Event_Repeat, 0);
        check("init_drop", o_Drop, 0);
        @(posedge i_Clk);
        @(posedge i_Clk);
        #2 i_Rst_L = 1'b1;

        // Short press of button 2.
        run_n(4'b0000, 1'b1, 2);
        run_n(4'b0100, 1'b1, 3);
        run_n(4'b0000, 1'b1, 15);

        // Three simultaneous presses drain on consecutive cycles.
        run_n(4'b1011, 1'b1, 1);
        run_n(4'b0000, 1'b1, 6);

        // Long hold of button 1 produces the repeat train.
        run_n(4'b0010, 1'b1, 30);
        run_n(4'b0000, 1'b1, 10);

        // Stalled consumer: third press of button 0 is dropped.
        run_cycle(4'b0001, 1'b0);
        run_cycle(4'b0000, 1'b0);
        run_cycle(4'b0001, 1'b0);
        run_cycle(4'b0000, 1'b0);
        run_cycle(4'b0001, 1'b0);
        run_n(4'b0000, 1'b0, 2);
        run_n(4'b0000, 1'b1, 8);

        // Buttons held through reset release are not presses.
        do_async_reset(4'b1111);
        run_n(4'b1111, 1'b1, 5);
        run_n(4'b0111, 1'b1, 2);
        run_n(4'b1111, 1'b1, 3);
        run_n(4'b0000, 1'b1, 5);

        // Reset in the middle of a repeat train with the output stalled.
        run_n(4'b0010, 1'b1, 16);
        run_n(4'b0010, 1'b0, 3);
        do_async_reset(4'b0010);
        run_n(4'b0010, 1'b1, 15);
        run_n(4'b0000, 1'b1, 3);

        // Random traffic: mostly-ready first, then mostly-stalled.
        btn = '0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                k      = $urandom_range(0, NB - 1);
                btn[k] = ~btn[k];
            end
            if (c < 1500) rdy = ($urandom_range(0, 3) != 0);
            else          rdy = ($urandom_range(0, 3) == 0);
            if (c == 2000) do_async_reset(btn);
            run_cycle(btn, rdy);
        end
        run_n(4'b0000, 1'b1, 10);
        @(negedge i_Clk);
        compare_outputs();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
